// File: rtl/xif_result_buffer.sv
// xif_result_buffer: result FIFO decoupling the vector unit writeback from the core's XIF result port
module xif_result_buffer #(
  parameter int Depth     = 2,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [IdWidth-1:0]       in_id_i,
  input  logic                     in_we_i,
  input  logic                     in_err_i,
  input  logic [DataWidth-1:0]     in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [IdWidth-1:0]       out_id_o,
  output logic                     out_we_o,
  output logic                     out_err_o,
  output logic [DataWidth-1:0]     out_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     err_seen_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  logic [IdWidth-1:0]   id_q   [Depth];
  logic                 we_q   [Depth];
  logic                 err_q  [Depth];
  logic [DataWidth-1:0] data_q [Depth];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 err_seen_q, push, pop;
  // Handshake flags come from registered occupancy only, so no ready/valid path crosses the buffer.
  assign in_ready_o  = count_q != CW'(Depth);
  assign out_valid_o = count_q != '0;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_id_o    = out_valid_o ? id_q[rd_ptr]   : '0;
  assign out_we_o    = out_valid_o ? we_q[rd_ptr]   : 1'b0;
  assign out_err_o   = out_valid_o ? err_q[rd_ptr]  : 1'b0;
  assign out_data_o  = out_valid_o ? data_q[rd_ptr] : '0;
  assign count_o     = count_q;
  assign err_seen_o  = err_seen_q;
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr]   <= in_id_i;
      we_q[wr_ptr]   <= in_we_i;
      err_q[wr_ptr]  <= in_err_i;
      data_q[wr_ptr] <= in_data_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      err_seen_q <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        wr_ptr  <= wr_ptr + AW'(push);
        rd_ptr  <= rd_ptr + AW'(pop);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      if (pop && out_err_o) err_seen_q <= 1'b1;
    end
  end
  a_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push |-> count_q != CW'(Depth));
  a_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> count_q != '0);
  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable({out_id_o, out_we_o, out_err_o, out_data_o})));
endmodule

// File: tb/tb_xif_result_buffer.sv
// tb_xif_result_buffer: directed and random stimulus checked every cycle against a queue model
module tb_xif_result_buffer;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_we = 0, in_err = 0, out_ready = 0;
  logic [5:0] in_id = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_we, out_err, err_seen;
  logic [5:0] out_id;
  logic [31:0] out_data;
  logic [1:0] count;
  int checks = 0, failures = 0;
  typedef struct { logic [5:0] id; logic we; logic err; logic [31:0] data; } ent_t;
  ent_t q[$];
  logic m_err = 0;
  xif_result_buffer #(.Depth(DEPTH), .DataWidth(32), .IdWidth(6)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_id_i(in_id), .in_we_i(in_we),
    .in_err_i(in_err), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id), .out_we_o(out_we),
    .out_err_o(out_err), .out_data_o(out_data), .count_o(count), .err_seen_o(err_seen));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a FIFO of whole entries; occupancy and head come straight from the queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_err = 0;
    end else begin
      automatic bit pop = out_ready && q.size() != 0;
      automatic bit push = in_valid && q.size() < DEPTH;
      if (pop && q[0].err) m_err = 1;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{in_id, in_we, in_err, in_data});
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit v = q.size() != 0;
      chk("out_valid", out_valid, v);
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("count", count, q.size());
      chk("err_seen", err_seen, m_err);
      chk("out_id", out_id, v ? q[0].id : 6'd0);
      chk("out_we", out_we, v ? q[0].we : 1'b0);
      chk("out_err", out_err, v ? q[0].err : 1'b0);
      chk("out_data", out_data, v ? q[0].data : 32'd0);
    end
  end
  task automatic drive(input logic v, input logic [5:0] id, input logic we, input logic err,
                       input logic [31:0] d, input logic rdy, input logic fl);
    in_valid = v; in_id = id; in_we = we; in_err = err; in_data = d; out_ready = rdy; flush = fl;
    @(posedge clk); #1;
  endtask
  task automatic idle(input logic rdy);
    drive(0, 0, 0, 0, 0, rdy, 0);
  endtask
  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_err_seen", err_seen, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk); #1 rst = 0;
    // single result
    drive(1, 5, 1, 0, 32'hDEADBEEF, 0, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_id", out_id, 5);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("single_hold", out_data, 32'hDEADBEEF);
    idle(1);
    chk("single_popped", count, 0);
    // fill and backpressure
    drive(1, 1, 1, 0, 32'h11, 0, 0);
    drive(1, 2, 0, 0, 32'h22, 0, 0);
    chk("fill_count", count, 2);
    chk("fill_ready", in_ready, 0);
    drive(1, 3, 1, 0, 32'h33, 0, 0);
    chk("held_count", count, 2);
    chk("held_head", out_id, 1);
    drive(1, 3, 1, 0, 32'h33, 1, 0);
    chk("drain1_head", out_id, 2);
    chk("drain1_count", count, 1);
    drive(1, 3, 1, 0, 32'h33, 1, 0);
    chk("drain2_head", out_id, 3);
    idle(1);
    chk("drain_empty", out_valid, 0);
    // streaming with pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1, 6'(i), 1, 0, 32'(i), 1, 0);
      chk("stream_count", count, 1);
      chk("stream_data", out_data, 32'(i));
    end
    idle(1);
    // flush with concurrent push
    drive(1, 8, 1, 0, 32'h88, 0, 0);
    drive(1, 9, 1, 0, 32'h99, 0, 0);
    drive(1, 7, 1, 0, 32'h77, 0, 1);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    idle(1);
    chk("flush_no7", out_valid, 0);
    // error sticky
    drive(1, 4, 1, 1, 32'hE, 0, 0);
    chk("err_before_pop", err_seen, 0);
    idle(1);
    chk("err_set", err_seen, 1);
    drive(1, 4, 1, 0, 32'h1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("err_after_flush", err_seen, 1);
    // asynchronous reset mid-cycle with one entry buffered
    drive(1, 10, 1, 0, 32'hA, 0, 0);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_err_seen", err_seen, 0);
    @(posedge clk); #1 rst = 0;
    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, 6'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
            $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    idle(1);
    idle(1);
    chk("final_empty", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
